// File: rtl/fa_tag_lookup.sv
// fa_tag_lookup: fully associative tag/data store with a registered lookup
// port, a refill port with victim selection, and a used pulse for the PLRU tree.
//
// Ports:
//   clk_i, rst_i         clock, async active-high reset
//   flush_i, busy_o      invalidate all entries; busy_o is high in FLUSH
//   lookup_*             valid/ready request, tag to search
//   hit_valid_o, hit_o   registered result pulse and hit flag
//   hit_idx_o, data_o    index and payload of the hit
//   refill_*             valid/ready request, tag and payload to install
//   used_o, plru_i       one-hot used pulse out, one-hot LRU hint in
module fa_tag_lookup #(
  parameter int ENTRIES    = 16,
  parameter int TAG_WIDTH  = 20,
  parameter int DATA_WIDTH = 32,
  localparam int IW        = $clog2(ENTRIES)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  lookup_valid_i,
  output logic                  lookup_ready_o,
  input  logic [TAG_WIDTH-1:0]  lookup_tag_i,
  output logic                  hit_valid_o,
  output logic                  hit_o,
  output logic [IW-1:0]         hit_idx_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  refill_valid_i,
  output logic                  refill_ready_o,
  input  logic [TAG_WIDTH-1:0]  refill_tag_i,
  input  logic [DATA_WIDTH-1:0] refill_data_i,
  output logic [ENTRIES-1:0]    used_o,
  input  logic [ENTRIES-1:0]    plru_i,
  output logic                  busy_o
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [0:0]            state_q;
  logic [ENTRIES-1:0]    valid_q;
  logic [TAG_WIDTH-1:0]  tag_q  [ENTRIES];
  logic [DATA_WIDTH-1:0] pay_q  [ENTRIES];

  logic                  ready;
  logic                  lookup_acc;
  logic                  refill_acc;

  logic [ENTRIES-1:0]    lk_match;
  logic                  lk_hit;
  logic [IW-1:0]         lk_idx;

  logic [ENTRIES-1:0]    rf_match;
  logic                  rf_hit;
  logic [IW-1:0]         rf_idx;
  logic                  inv_any;
  logic [IW-1:0]         inv_idx;
  logic                  plru_any;
  logic [IW-1:0]         plru_idx;
  logic [IW-1:0]         victim;

  assign ready          = ~rst_i & (state_q == S_IDLE) & ~flush_i;
  assign lookup_ready_o = ready;
  assign refill_ready_o = ready;
  assign lookup_acc     = lookup_valid_i & ready;
  assign refill_acc     = refill_valid_i & ready;
  assign busy_o         = (state_q == S_FLUSH);

  // Match vectors and lowest-index encoders (descending loop = lowest wins).
  always_comb begin
    lk_match = '0;
    rf_match = '0;
    lk_idx   = '0;
    rf_idx   = '0;
    inv_idx  = '0;
    plru_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      lk_match[i] = valid_q[i] && (tag_q[i] == lookup_tag_i);
      rf_match[i] = valid_q[i] && (tag_q[i] == refill_tag_i);
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (lk_match[i]) lk_idx = IW'(i);
      if (rf_match[i]) rf_idx = IW'(i);
      if (!valid_q[i]) inv_idx = IW'(i);
      if (plru_i[i])   plru_idx = IW'(i);
    end
    lk_hit   = |lk_match;
    rf_hit   = |rf_match;
    inv_any  = ~&valid_q;
    plru_any = |plru_i;
  end

  // Same-tag overwrite first so duplicates never form.
  always_comb begin
    victim = '0;
    if (rf_hit)        victim = rf_idx;
    else if (inv_any)  victim = inv_idx;
    else if (plru_any) victim = plru_idx;
  end

  // Refill pulse takes precedence over the previous lookup's hit pulse.
  always_comb begin
    used_o = '0;
    if (refill_acc)
      used_o[victim] = 1'b1;
    else if (hit_valid_o && hit_o)
      used_o[hit_idx_o] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      hit_valid_o <= 1'b0;
      hit_o       <= 1'b0;
      hit_idx_o   <= '0;
      data_o      <= '0;
    end else begin
      state_q <= flush_i ? S_FLUSH : S_IDLE;
      if (state_q == S_FLUSH)
        valid_q <= '0;
      else if (refill_acc)
        valid_q[victim] <= 1'b1;
      hit_valid_o <= lookup_acc;
      if (lookup_acc) begin
        hit_o     <= lk_hit;
        hit_idx_o <= lk_hit ? lk_idx : '0;
        data_o    <= lk_hit ? pay_q[lk_idx] : '0;
      end
    end
  end

  // Arrays carry no reset; valid_q qualifies them.
  always_ff @(posedge clk_i) begin
    if (refill_acc) begin
      tag_q[victim] <= refill_tag_i;
      pay_q[victim] <= refill_data_i;
    end
  end

  a_lk_onehot: assert property (
    @(posedge clk_i) disable iff (rst_i) $onehot0(lk_match));
  a_rf_onehot: assert property (
    @(posedge clk_i) disable iff (rst_i) $onehot0(rf_match));

endmodule

// File: tb/tb_fa_tag_lookup.sv
// tb_fa_tag_lookup: directed self-checking bench for fa_tag_lookup.
// Vectors carry hand-computed expectations.
module tb_fa_tag_lookup;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        lookup_valid_i;
  logic        lookup_ready_o;
  logic [19:0] lookup_tag_i;
  logic        hit_valid_o;
  logic        hit_o;
  logic [3:0]  hit_idx_o;
  logic [31:0] data_o;
  logic        refill_valid_i;
  logic        refill_ready_o;
  logic [19:0] refill_tag_i;
  logic [31:0] refill_data_i;
  logic [15:0] used_o;
  logic [15:0] plru_i;
  logic        busy_o;

  int n_chk  = 0;
  int n_fail = 0;

  fa_tag_lookup #(
    .ENTRIES(16), .TAG_WIDTH(20), .DATA_WIDTH(32)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .lookup_valid_i (lookup_valid_i),
    .lookup_ready_o (lookup_ready_o),
    .lookup_tag_i   (lookup_tag_i),
    .hit_valid_o    (hit_valid_o),
    .hit_o          (hit_o),
    .hit_idx_o      (hit_idx_o),
    .data_o         (data_o),
    .refill_valid_i (refill_valid_i),
    .refill_ready_o (refill_ready_o),
    .refill_tag_i   (refill_tag_i),
    .refill_data_i  (refill_data_i),
    .used_o         (used_o),
    .plru_i         (plru_i),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Advance one clock, drop request strobes, settle away from the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
    lookup_valid_i = 1'b0;
    refill_valid_i = 1'b0;
    flush_i        = 1'b0;
    #1;
  endtask

  task automatic refill(input logic [19:0] tag,
                        input logic [31:0] data,
                        input logic [15:0] plru);
    refill_valid_i = 1'b1;
    refill_tag_i   = tag;
    refill_data_i  = data;
    plru_i         = plru;
    #1;
  endtask

  task automatic lookup(input logic [19:0] tag);
    lookup_valid_i = 1'b1;
    lookup_tag_i   = tag;
    step();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
  endtask

  initial begin
    rst_i          = 1'b1;
    flush_i        = 1'b0;
    lookup_valid_i = 1'b0;
    lookup_tag_i   = '0;
    refill_valid_i = 1'b0;
    refill_tag_i   = '0;
    refill_data_i  = '0;
    plru_i         = '0;
    repeat (2) @(posedge clk_i);
    #2;
    chk("rst_hit_valid", 64'(hit_valid_o), 64'h0);
    chk("rst_hit", 64'(hit_o), 64'h0);
    chk("rst_idx", 64'(hit_idx_o), 64'h0);
    chk("rst_data", 64'(data_o), 64'h0);
    chk("rst_used", 64'(used_o), 64'h0);
    chk("rst_busy", 64'(busy_o), 64'h0);
    rst_i = 1'b0;
    #1;
    chk("rdy_lookup", 64'(lookup_ready_o), 64'h1);
    chk("rdy_refill", 64'(refill_ready_o), 64'h1);

    // 1: lookup on empty store
    lookup(20'h12345);
    chk("t1_hv", 64'(hit_valid_o), 64'h1);
    chk("t1_hit", 64'(hit_o), 64'h0);
    chk("t1_used", 64'(used_o), 64'h0);
    step();
    chk("t1_hv_drop", 64'(hit_valid_o), 64'h0);

    // 2: single refill then hit
    refill(20'h000AA, 32'hDEADBEEF, 16'h0);
    chk("t2_used_rf", 64'(used_o), 64'h0001);
    step();
    lookup(20'h000AA);
    chk("t2_hit", 64'(hit_o), 64'h1);
    chk("t2_idx", 64'(hit_idx_o), 64'h0);
    chk("t2_data", 64'(data_o), 64'hDEADBEEF);
    chk("t2_used", 64'(used_o), 64'h0001);

    // 3: fill tags 0..15, then PLRU victim
    do_reset();
    for (int i = 0; i < 16; i++) begin
      refill(20'(i), 32'(32'h1000 + i), 16'h0020);
      if (i == 9) chk("t3_used_fill9", 64'(used_o), 64'h0200);
      step();
    end
    refill(20'h100, 32'hCAFE, 16'h0020);
    chk("t3_used_plru", 64'(used_o), 64'h0020);
    step();
    lookup(20'h5);
    chk("t3_tag5_miss", 64'(hit_o), 64'h0);
    chk("t3_miss_data", 64'(data_o), 64'h0);
    lookup(20'h100);
    chk("t3_100_hit", 64'(hit_o), 64'h1);
    chk("t3_100_idx", 64'(hit_idx_o), 64'h5);
    chk("t3_100_data", 64'(data_o), 64'hCAFE);

    // 4: same-tag overwrite
    refill(20'h3, 32'h55, 16'h0001);
    chk("t4_used", 64'(used_o), 64'h0008);
    step();
    lookup(20'h3);
    chk("t4_hit", 64'(hit_o), 64'h1);
    chk("t4_idx", 64'(hit_idx_o), 64'h3);
    chk("t4_data", 64'(data_o), 64'h55);

    // multi-bit plru -> lowest set bit; zero plru -> entry 0
    refill(20'h200, 32'h77, 16'h0030);
    chk("plru_multi", 64'(used_o), 64'h0010);
    step();
    refill(20'h300, 32'h88, 16'h0000);
    chk("plru_zero", 64'(used_o), 64'h0001);
    step();
    lookup(20'h300);
    chk("plru_zero_idx", 64'(hit_idx_o), 64'h0);
    chk("plru_zero_data", 64'(data_o), 64'h88);

    // 6a: hit on entry 2 and refill into entry 7 in the same cycle
    lookup(20'h2);
    refill(20'h400, 32'h99, 16'h0080);
    chk("t6_hv", 64'(hit_valid_o), 64'h1);
    chk("t6_idx", 64'(hit_idx_o), 64'h2);
    chk("t6_used", 64'(used_o), 64'h0080);
    step();

    // same-cycle lookup of the tag being refilled sees old contents
    lookup_valid_i = 1'b1;
    lookup_tag_i   = 20'h500;
    refill(20'h500, 32'h11, 16'h0100);
    step();
    chk("same_cyc_miss", 64'(hit_o), 64'h0);
    lookup(20'h500);
    chk("same_cyc_after", 64'(hit_idx_o), 64'h8);

    // 5: flush with a lookup pending
    flush_i        = 1'b1;
    lookup_valid_i = 1'b1;
    lookup_tag_i   = 20'h400;
    #1;
    chk("t5_lk_rdy", 64'(lookup_ready_o), 64'h0);
    chk("t5_rf_rdy", 64'(refill_ready_o), 64'h0);
    step();
    chk("t5_busy", 64'(busy_o), 64'h1);
    chk("t5_no_result", 64'(hit_valid_o), 64'h0);
    step();
    chk("t5_busy_done", 64'(busy_o), 64'h0);
    lookup(20'h400);
    chk("t5_miss_400", 64'(hit_o), 64'h0);
    lookup(20'h2);
    chk("t5_miss_2", 64'(hit_o), 64'h0);

    // flush held two cycles keeps FLUSH
    flush_i = 1'b1;
    @(posedge clk_i);
    #2;
    chk("flush_hold1", 64'(busy_o), 64'h1);
    step();
    chk("flush_hold2", 64'(busy_o), 64'h1);
    step();
    chk("flush_hold_exit", 64'(busy_o), 64'h0);

    // 6b: reset mid-stream drops the pending result
    refill(20'h9, 32'h42, 16'h0);
    step();
    lookup(20'h9);
    chk("t6_pre_hit", 64'(hit_o), 64'h1);
    lookup(20'h9);
    rst_i = 1'b1;
    #1;
    chk("t6_rst_hv", 64'(hit_valid_o), 64'h0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    chk("t6_rst_hv_next", 64'(hit_valid_o), 64'h0);
    lookup(20'h9);
    chk("t6_post_miss", 64'(hit_o), 64'h0);
    chk("t6_post_used", 64'(used_o), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
